// File: rtl/cpu_hs.sv
`timescale 1ns/1ps
// cpu_hs: multicycle accumulator CPU with ready/valid IN/OUT, status outputs and generic widths.
// Define CPU_HS_DIV_EN to build the iterative restoring divider; otherwise DIV is a no-op.
module cpu_hs #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int PC_START   = 8,
   parameter int SP_START   = 2**ADDR_WIDTH-1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic                  halted,
   output logic                  error
);
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   localparam logic [3:0] OP_MOV  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_DIV  = 4'h4;
   localparam logic [3:0] OP_IN   = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_STOP = 4'hF;

   typedef enum logic [3:0] {
      S_FETCH0, S_FETCH1, S_DECODE, S_IMM0, S_IMM1, S_OPA, S_OPD, S_WPA,
      S_WPD, S_WR, S_DIV, S_IN, S_OUT, S_STOP, S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [AW-1:0]   sp_q;
   logic [15:0]     ir_q, ir_d;
   logic [DW-1:0]   acc_q, acc_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [1:0]      opidx_q, opidx_d;
   logic            ind_done_q, ind_done_d;
   logic [DW-1:0]   out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            error_q, error_d;

   logic            mem_we_c;
   logic [AW-1:0]   mem_addr_c;
   logic [DW-1:0]   mem_data_c;
   logic            in_ready_c;

   logic [3:0]      opcode;
   logic [3:0]      cur_fld;
   logic [AW-1:0]   cur_addr;
   logic [AW-1:0]   a1_addr;
   logic [AW-1:0]   dst_addr;
   state_t          dst_state;
   logic [DW-1:0]   alu_res;

   assign opcode    = ir_q[15:12];
   assign a1_addr   = {{(AW-3){1'b0}}, ir_q[10:8]};
   assign dst_addr  = ir_q[11] ? ptr_q : a1_addr;
   assign dst_state = ir_q[11] ? S_WPA : S_WR;
   assign cur_addr  = {{(AW-3){1'b0}}, cur_fld[2:0]};

   always_comb begin
      cur_fld = 4'h0;
      case (opidx_q)
         2'd1:    cur_fld = ir_q[11:8];
         2'd2:    cur_fld = ir_q[7:4];
         2'd3:    cur_fld = ir_q[3:0];
         default: cur_fld = 4'h0;
      endcase
   end

   always_comb begin
      alu_res = acc_q + mem_in;
      case (opcode)
         OP_SUB:  alu_res = acc_q - mem_in;
         OP_MUL:  alu_res = acc_q * mem_in;
         default: alu_res = acc_q + mem_in;
      endcase
   end

`ifdef CPU_HS_DIV_EN
   localparam int CW = $clog2(DW);
   logic [DW-1:0] rem_q, rem_d;
   logic [DW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW:0]   div_shift;
   logic [DW:0]   div_diff;

   // Restoring step: shift next dividend bit into the remainder, keep the subtraction if no borrow.
   assign div_shift = {rem_q, acc_q[DW-1]};
   assign div_diff  = div_shift - {1'b0, dvs_q};
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      acc_d       = acc_q;
      ptr_d       = ptr_q;
      opidx_d     = opidx_q;
      ind_done_d  = ind_done_q;
      out_d       = out_q;
      out_valid_d = out_valid_q & ~out_ready;
      error_d     = error_q;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_data_c  = '0;
      in_ready_c  = 1'b0;
`ifdef CPU_HS_DIV_EN
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
`endif
      case (state_q)
         S_FETCH0: begin
            mem_addr_c = pc_q;
            state_d    = S_FETCH1;
         end
         S_FETCH1: begin
            ir_d    = mem_in[15:0];
            pc_d    = pc_q + 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ind_done_d = 1'b0;
            opidx_d    = 2'd2;
            case (opcode)
               OP_MOV: begin
                  if (ir_q[3:0] == 4'b0000) begin
                     state_d = S_OPA;
                  end else if (ir_q[3:0] == 4'b1000) begin
                     state_d = S_IMM0;
                  end else begin
                     error_d = 1'b1;
                     state_d = S_HALT;
                  end
               end
               OP_ADD, OP_SUB, OP_MUL: state_d = S_OPA;
`ifdef CPU_HS_DIV_EN
               OP_DIV:  state_d = S_OPA;
`else
               OP_DIV:  state_d = S_FETCH0;
`endif
               OP_IN:   state_d = ir_q[11] ? S_WPA : S_IN;
               OP_OUT: begin
                  opidx_d = 2'd1;
                  state_d = S_OPA;
               end
               OP_STOP: begin
                  opidx_d = 2'd1;
                  state_d = S_STOP;
               end
               default: begin
                  error_d = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_IMM0: begin
            mem_addr_c = pc_q;
            state_d    = S_IMM1;
         end
         S_IMM1: begin
            acc_d   = mem_in;
            pc_d    = pc_q + 1'b1;
            state_d = dst_state;
         end
         S_OPA: begin
            mem_addr_c = ind_done_q ? ptr_q : cur_addr;
            state_d    = S_OPD;
         end
         S_OPD: begin
            if (cur_fld[3] && !ind_done_q) begin
               ptr_d      = mem_in[AW-1:0];
               ind_done_d = 1'b1;
               state_d    = S_OPA;
            end else begin
               ind_done_d = 1'b0;
               case (opcode)
                  OP_MOV: begin
                     acc_d   = mem_in;
                     state_d = dst_state;
                  end
                  OP_OUT, OP_STOP: begin
                     acc_d   = mem_in;
                     state_d = S_OUT;
                  end
                  default: begin
                     if (opidx_q == 2'd2) begin
                        acc_d   = mem_in;
                        opidx_d = 2'd3;
                        state_d = S_OPA;
`ifdef CPU_HS_DIV_EN
                     end else if (opcode == OP_DIV) begin
                        dvs_d   = mem_in;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
`endif
                     end else begin
                        acc_d   = alu_res;
                        state_d = dst_state;
                     end
                  end
               endcase
            end
         end
         S_WPA: begin
            mem_addr_c = a1_addr;
            state_d    = S_WPD;
         end
         S_WPD: begin
            ptr_d   = mem_in[AW-1:0];
            state_d = (opcode == OP_IN) ? S_IN : S_WR;
         end
         S_WR: begin
            mem_we_c   = 1'b1;
            mem_addr_c = dst_addr;
            mem_data_c = acc_q;
            state_d    = S_FETCH0;
         end
`ifdef CPU_HS_DIV_EN
         S_DIV: begin
            if (!div_diff[DW]) begin
               rem_d = div_diff[DW-1:0];
               acc_d = {acc_q[DW-2:0], 1'b1};
            end else begin
               rem_d = div_shift[DW-1:0];
               acc_d = {acc_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW-1)) begin
               state_d = dst_state;
            end
         end
`endif
         S_IN: begin
            in_ready_c = 1'b1;
            mem_addr_c = dst_addr;
            mem_data_c = in;
            if (in_valid) begin
               mem_we_c = 1'b1;
               state_d  = S_FETCH0;
            end
         end
         S_OUT: begin
            // Single-entry buffer: only stall while the previous value is still refused.
            if (!(out_valid_q && !out_ready)) begin
               out_d       = acc_q;
               out_valid_d = 1'b1;
               if (opcode == OP_STOP) begin
                  opidx_d = opidx_q + 2'd1;
                  state_d = S_STOP;
               end else begin
                  state_d = S_FETCH0;
               end
            end
         end
         S_STOP: begin
            // opidx wraps to 0 once all three operands have been visited.
            if (opidx_q == 2'd0) begin
               if (!out_valid_q) begin
                  state_d = S_HALT;
               end
            end else if (cur_fld[2:0] == 3'd0) begin
               opidx_d = opidx_q + 2'd1;
            end else if (!out_valid_q) begin
               ind_done_d = 1'b0;
               state_d    = S_OPA;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH0;
         pc_q        <= AW'(PC_START);
         sp_q        <= AW'(SP_START);
         ir_q        <= '0;
         acc_q       <= '0;
         ptr_q       <= '0;
         opidx_q     <= '0;
         ind_done_q  <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sp_q        <= sp_q;
         ir_q        <= ir_d;
         acc_q       <= acc_d;
         ptr_q       <= ptr_d;
         opidx_q     <= opidx_d;
         ind_done_q  <= ind_done_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         error_q     <= error_d;
      end
   end

`ifdef CPU_HS_DIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end
`endif

   // Memory port is held idle while reset is asserted so no write lands after rst_n falls.
   assign mem_we    = mem_we_c & rst_n;
   assign mem_addr  = rst_n ? mem_addr_c : '0;
   assign mem_data  = rst_n ? mem_data_c : '0;
   assign in_ready  = in_ready_c;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign pc        = pc_q;
   assign sp        = sp_q;
   assign halted    = (state_q == S_HALT);
   assign error     = error_q;

endmodule

// File: tb/tb_cpu_hs.sv
`timescale 1ns/1ps
// tb_cpu_hs: directed programs for cpu_hs against a synchronous memory model with immediate-assertion checks.
module tb_cpu_hs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_in;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [15:0] mem_data;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  pc;
   logic [5:0]  sp;
   logic        halted;
   logic        error;

   logic [15:0] mem [0:63];
   logic [15:0] mem_rd = '0;
   logic        ld_we = 1'b0;
   logic [5:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   int          cyc = 0;
   int          tests_run = 0;
   int          tests_failed = 0;

   cpu_hs dut (
      .clk(clk), .rst_n(rst_n), .mem_in(mem_in), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_data(mem_data), .in(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .pc(pc), .sp(sp), .halted(halted), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_we) mem[ld_addr] <= ld_data;
      else if (mem_we) mem[mem_addr] <= mem_data;
      mem_rd <= mem[mem_addr];
   end
   assign mem_in = mem_rd;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) begin
         $display("[TB] %s ok (%h)", tag, obs);
      end else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [5:0] a, input logic [15:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_we = 1'b0;
   endtask

   task automatic start_test();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      for (int i = 0; i < 64; i++) load(6'(i), 16'h0000);
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_halted"}, {31'd0, halted}, 32'd1);
   endtask

   task automatic wait_pc(input logic [5:0] target, output int t);
      int n = 0;
      while (pc !== target && n < 200) begin
         tick();
         n++;
      end
      check("pc_reached", {26'd0, pc}, {26'd0, target});
      t = cyc;
   endtask

   task automatic check_reset(input string p);
      check({p, "_pc"},        {26'd0, pc}, 32'd8);
      check({p, "_sp"},        {26'd0, sp}, 32'd63);
      check({p, "_out"},       {16'd0, out_data}, 32'd0);
      check({p, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({p, "_in_ready"},  {31'd0, in_ready}, 32'd0);
      check({p, "_halted"},    {31'd0, halted}, 32'd0);
      check({p, "_error"},     {31'd0, error}, 32'd0);
      check({p, "_mem_we"},    {31'd0, mem_we}, 32'd0);
      check({p, "_mem_addr"},  {26'd0, mem_addr}, 32'd0);
      check({p, "_mem_data"},  {16'd0, mem_data}, 32'd0);
   endtask

   initial begin
      int cnt;
      int t9, t10, t11;
      int nvals;
      logic [15:0] vals [0:3];

      // Reset values
      start_test();
      check_reset("rst");

      // MOV immediate then OUT, value held until consumed
      start_test();
      load(6'd8, 16'h0108); load(6'd9, 16'h1234); load(6'd10, 16'h8100); load(6'd11, 16'hF000);
      release_reset();
      for (int i = 0; i < 30; i++) tick();
      check("movi_mem1", {16'd0, mem[1]}, 32'h1234);
      check("movi_out", {16'd0, out_data}, 32'h1234);
      check("movi_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("movi_out_valid_clr", {31'd0, out_valid}, 32'd0);
      wait_halt("movi", 50);

      // IN handshake with 10 idle cycles
      start_test();
      load(6'd8, 16'h7200); load(6'd9, 16'hF000);
      release_reset();
      cnt = 0;
      while (!in_ready && cnt < 20) begin tick(); cnt++; end
      check("in_ready_rise", {31'd0, in_ready}, 32'd1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (in_ready) cnt++;
      end
      check("in_ready_10cyc", cnt, 32'd10);
      in_data = 16'h00AB; in_valid = 1'b1;
      check("in_ready_11th", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("in_ready_drop", {31'd0, in_ready}, 32'd0);
      wait_halt("in", 50);
      check("in_mem2", {16'd0, mem[2]}, 32'h00AB);

      // Indirect ALU, MUL wrap, SUB, indirect destination with truncated pointer
      start_test();
      load(6'd0, 16'h1111); load(6'd2, 16'h5555); load(6'd3, 16'd5); load(6'd4, 16'd9);
      load(6'd5, 16'd7); load(6'd6, 16'h0100);
      load(6'd8, 16'h11B4); load(6'd9, 16'h3266); load(6'd10, 16'h2743);
      load(6'd11, 16'h0E50); load(6'd12, 16'hF000);
      release_reset();
      wait_halt("alu", 200);
      check("add_ind", {16'd0, mem[1]}, 32'd16);
      check("mul_wrap", {16'd0, mem[2]}, 32'd0);
      check("sub", {16'd0, mem[7]}, 32'd4);
      check("mov_ind_dst", {16'd0, mem[0]}, 32'd7);
      check("alu_error", {31'd0, error}, 32'd0);

      // DIV timing and results
      start_test();
      load(6'd1, 16'd100); load(6'd2, 16'd7); load(6'd3, 16'd5); load(6'd4, 16'd0);
      load(6'd6, 16'h6666); load(6'd7, 16'h7777);
      load(6'd8, 16'h1512); load(6'd9, 16'h4612); load(6'd10, 16'h4734); load(6'd11, 16'hF000);
      release_reset();
      wait_pc(6'd9, t9);
      wait_pc(6'd10, t10);
      wait_pc(6'd11, t11);
      wait_halt("div", 300);
      check("div_add_ref", {16'd0, mem[5]}, 32'd107);
`ifdef CPU_HS_DIV_EN
      check("div_extra_cycles", (t11 - t10) - (t10 - t9), 32'd16);
      check("div_100_7", {16'd0, mem[6]}, 32'd14);
      check("div_by_zero", {16'd0, mem[7]}, 32'hFFFF);
`else
      check("div_noop_cycles", t11 - t10, 32'd3);
      check("div_noop_dst6", {16'd0, mem[6]}, 32'h6666);
      check("div_noop_dst7", {16'd0, mem[7]}, 32'h7777);
`endif
      check("div_error", {31'd0, error}, 32'd0);

      // Back-pressure: second OUT stalls until the first is consumed
      start_test();
      load(6'd1, 16'h0AAA); load(6'd2, 16'h0BBB);
      load(6'd8, 16'h8100); load(6'd9, 16'h8200); load(6'd10, 16'hF000);
      release_reset();
      for (int i = 0; i < 40; i++) tick();
      check("bp_out_first", {16'd0, out_data}, 32'h0AAA);
      check("bp_valid_first", {31'd0, out_valid}, 32'd1);
      check("bp_pc_stalled", {26'd0, pc}, 32'd10);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_out_second", {16'd0, out_data}, 32'h0BBB);
      check("bp_valid_second", {31'd0, out_valid}, 32'd1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_valid_clr", {31'd0, out_valid}, 32'd0);
      wait_halt("bp", 50);

      // STOP 1,0,3: two handshakes then frozen
      start_test();
      load(6'd1, 16'h0111); load(6'd3, 16'h0333); load(6'd8, 16'hF103);
      release_reset();
      out_ready = 1'b1;
      nvals = 0;
      cnt = 0;
      while (!halted && cnt < 100) begin
         tick();
         cnt++;
         if (out_valid) begin
            if (nvals < 4) vals[nvals] = out_data;
            nvals++;
         end
      end
      check("stop_halted", {31'd0, halted}, 32'd1);
      check("stop_handshakes", nvals, 32'd2);
      check("stop_val0", {16'd0, vals[0]}, 32'h0111);
      check("stop_val1", {16'd0, vals[1]}, 32'h0333);
      for (int i = 0; i < 5; i++) tick();
      check("stop_pc_frozen", {26'd0, pc}, 32'd9);
      check("stop_mem_we", {31'd0, mem_we}, 32'd0);
      check("stop_error", {31'd0, error}, 32'd0);
      out_ready = 1'b0;

      // Illegal opcode
      start_test();
      load(6'd8, 16'h5000);
      release_reset();
      wait_halt("illegal", 30);
      check("illegal_error", {31'd0, error}, 32'd1);
      check("illegal_pc", {26'd0, pc}, 32'd9);

      // Illegal MOV form
      start_test();
      load(6'd8, 16'h0123);
      release_reset();
      wait_halt("movbad", 30);
      check("movbad_error", {31'd0, error}, 32'd1);

      // Reset asserted mid-DIV
      start_test();
      load(6'd1, 16'd100); load(6'd2, 16'd7); load(6'd6, 16'h6666);
      load(6'd8, 16'h1512); load(6'd9, 16'h4612); load(6'd10, 16'hF000);
      release_reset();
      for (int i = 0; i < 20; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      for (int i = 0; i < 3; i++) tick();
      check("midrst_no_write", {16'd0, mem[6]}, 32'h6666);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
